// File: rtl/joybus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : joybus_pkg
// Description : Joybus command codes, response lengths and scheduler types.
// Revision    : 1.0 - initial release
// ============================================================================
package joybus_pkg;

    localparam logic [7:0] CMD_INFO     = 8'h00;
    localparam logic [7:0] CMD_POLL     = 8'h01;
    localparam logic [3:0] INFO_RSP_LEN = 4'd3;
    localparam logic [3:0] POLL_RSP_LEN = 4'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_TX_WAIT = 3'd2,
        ST_RX_WAIT = 3'd3,
        ST_EVAL    = 3'd4,
        ST_GAP     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CK_INFO = 2'd0,
        CK_POLL = 2'd1,
        CK_HOST = 2'd2
    } cmd_kind_t;

    // Host commands have no known reply length, so any non-empty reply counts.
    function automatic logic rsp_len_ok(input cmd_kind_t kind, input logic [3:0] n);
        case (kind)
            CK_INFO: return n == INFO_RSP_LEN;
            CK_POLL: return n == POLL_RSP_LEN;
            default: return n != 4'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/joybus_poll_timer.sv
`default_nettype none
// ============================================================================
// Module      : joybus_poll_timer
// Description : Free-running poll period timer raising a sticky poll_due flag.
// Revision    : 1.0 - initial release
// ============================================================================
module joybus_poll_timer #(
    parameter int POLL_PERIOD = 833333
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable_i,
    input  logic clr_i,
    output logic poll_due_o
);

    localparam int             CW   = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [CW-1:0]  LAST = CW'(POLL_PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          due_q, due_d;

    // A wrap on the same cycle as a clear starts a fresh period, so set wins.
    always_comb begin
        cnt_d = cnt_q;
        due_d = due_q;
        if (!enable_i) begin
            cnt_d = '0;
            due_d = 1'b0;
        end else begin
            if (clr_i) begin
                due_d = 1'b0;
            end
            if (cnt_q == LAST) begin
                cnt_d = '0;
                due_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            due_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            due_q <= due_d;
        end
    end

    assign poll_due_o = due_q;

endmodule
`default_nettype wire

// File: rtl/joybus_poll_sched.sv
`default_nettype none
// ============================================================================
// Module      : joybus_poll_sched
// Description : Joybus controller poll scheduler with presence tracking.
//               Optional host command port enabled by JOYBUS_HOST_CMD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module joybus_poll_sched
    import joybus_pkg::*;
#(
    parameter int POLL_PERIOD = 833333,
    parameter int RX_TIMEOUT  = 10000,
    parameter int GAP_CYCLES  = 1000,
    parameter int MISS_LIMIT  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_i,
    input  logic       host_req_i,
    input  logic [7:0] host_cmd_i,
    output logic       host_ack_o,
    output logic       tx_start_o,
    output logic [7:0] tx_byte_o,
    input  logic       tx_done_i,
    input  logic       rx_done_i,
    input  logic [3:0] rx_byte_cnt_i,
    input  logic       rx_err_i,
    output logic       poll_stb_o,
    output logic       dev_present_o,
    output logic [7:0] timeout_cnt_o,
    output logic       busy_o
);

    localparam int             WMAX     = (RX_TIMEOUT > GAP_CYCLES) ? RX_TIMEOUT : GAP_CYCLES;
    localparam int             WW       = $clog2(WMAX + 1);
    localparam logic [WW-1:0]  RX_LAST  = WW'(RX_TIMEOUT - 1);
    localparam logic [WW-1:0]  GAP_LAST = WW'(GAP_CYCLES - 1);
    localparam int             MW       = $clog2(MISS_LIMIT + 1);
    localparam logic [MW-1:0]  MISS_LAST = MW'(MISS_LIMIT - 1);

    state_t          state_q, state_d;
    cmd_kind_t       kind_q, kind_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic            tx_start_q, tx_start_d;
    logic            host_ack_q, host_ack_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            ok_q, ok_d;
    logic [MW-1:0]   miss_q, miss_d;
    logic            dev_q, dev_d;
    logic            poll_stb_q, poll_stb_d;
    logic [7:0]      tmo_q, tmo_d;

    logic            w_poll_due;
    logic            w_poll_clr;
    logic            w_host_req;
    logic [7:0]      w_host_cmd;

`ifdef JOYBUS_HOST_CMD_EN
    assign w_host_req = host_req_i;
    assign w_host_cmd = host_cmd_i;
    assign host_ack_o = host_ack_q;
`else
    logic unused_host;
    assign w_host_req  = 1'b0;
    assign w_host_cmd  = CMD_INFO;
    assign host_ack_o  = 1'b0;
    assign unused_host = ^{host_req_i, host_cmd_i, host_ack_q};
`endif

    joybus_poll_timer #(
        .POLL_PERIOD (POLL_PERIOD)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable_i   (enable_i),
        .clr_i      (w_poll_clr),
        .poll_due_o (w_poll_due)
    );

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        tx_byte_d  = tx_byte_q;
        tx_start_d = 1'b0;
        host_ack_d = 1'b0;
        wait_d     = wait_q;
        ok_d       = ok_q;
        miss_d     = miss_q;
        dev_d      = dev_q;
        poll_stb_d = 1'b0;
        tmo_d      = tmo_q;
        w_poll_clr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                wait_d = '0;
                // Host request has priority; a pending poll stays due for later.
                if (enable_i && (w_host_req || w_poll_due)) begin
                    state_d = ST_ISSUE;
                    if (w_host_req) begin
                        kind_d = CK_HOST;
                    end else begin
                        kind_d     = dev_q ? CK_POLL : CK_INFO;
                        w_poll_clr = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                tx_start_d = 1'b1;
                state_d    = ST_TX_WAIT;
                case (kind_q)
                    CK_HOST: begin
                        tx_byte_d  = w_host_cmd;
                        host_ack_d = 1'b1;
                    end
                    CK_POLL: tx_byte_d = CMD_POLL;
                    default: tx_byte_d = CMD_INFO;
                endcase
            end
            ST_TX_WAIT: begin
                if (tx_done_i) begin
                    state_d = ST_RX_WAIT;
                    wait_d  = '0;
                end
            end
            ST_RX_WAIT: begin
                if (rx_done_i) begin
                    ok_d    = !rx_err_i && rsp_len_ok(kind_q, rx_byte_cnt_i);
                    state_d = ST_EVAL;
                end else if (wait_q == RX_LAST) begin
                    ok_d    = 1'b0;
                    state_d = ST_EVAL;
                    if (tmo_q != 8'hFF) begin
                        tmo_d = tmo_q + 8'd1;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_EVAL: begin
                state_d = ST_GAP;
                wait_d  = '0;
                if (ok_q) begin
                    miss_d     = '0;
                    dev_d      = 1'b1;
                    poll_stb_d = (kind_q == CK_POLL);
                end else if (miss_q == MISS_LAST) begin
                    miss_d = '0;
                    dev_d  = 1'b0;
                end else begin
                    miss_d = miss_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (wait_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            kind_q     <= CK_INFO;
            tx_byte_q  <= CMD_INFO;
            tx_start_q <= 1'b0;
            host_ack_q <= 1'b0;
            wait_q     <= '0;
            ok_q       <= 1'b0;
            miss_q     <= '0;
            dev_q      <= 1'b0;
            poll_stb_q <= 1'b0;
            tmo_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            tx_byte_q  <= tx_byte_d;
            tx_start_q <= tx_start_d;
            host_ack_q <= host_ack_d;
            wait_q     <= wait_d;
            ok_q       <= ok_d;
            miss_q     <= miss_d;
            dev_q      <= dev_d;
            poll_stb_q <= poll_stb_d;
            tmo_q      <= tmo_d;
        end
    end

    assign tx_start_o    = tx_start_q;
    assign tx_byte_o     = tx_byte_q;
    assign poll_stb_o    = poll_stb_q;
    assign dev_present_o = dev_q;
    assign timeout_cnt_o = tmo_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/joybus_poll_sched.md
JOYBUS_POLL_SCHED -- requirements
Module: joybus_poll_sched

Interface
REQ-001 Parameter POLL_PERIOD, default 833333, clk cycles between scheduled commands (60 Hz at 50 MHz).
REQ-002 Parameter RX_TIMEOUT, default 10000, clk cycles allowed from tx_done to rx_done.
REQ-003 Parameter GAP_CYCLES, default 1000, minimum idle cycles between end of one transaction and next tx_start.
REQ-004 Parameter MISS_LIMIT, default 3, consecutive failed transactions that clear dev_present.
REQ-005 clk  in  1  system clock, 50 MHz.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 enable  in  1  level; 1 permits issuing new commands.
REQ-008 host_req  in  1  level; host requests one-off command host_cmd.
REQ-009 host_cmd  in  8  host command byte, sampled on the cycle host_ack is 1.
REQ-010 host_ack  out  1  one-cycle pulse: host command issued.
REQ-011 tx_start  out  1  one-cycle pulse starting transmitter.
REQ-012 tx_byte  out  8  command byte; stable from tx_start until tx_done.
REQ-013 tx_done  in  1  one-cycle pulse: stop bit finished.
REQ-014 rx_done  in  1  one-cycle pulse: response receive finished.
REQ-015 rx_byte_cnt  in  4  bytes received, valid with rx_done.
REQ-016 rx_err  in  1  receive framing error, valid with rx_done.
REQ-017 poll_stb  out  1  one-cycle pulse: valid POLL response received.
REQ-018 dev_present  out  1  controller detected.
REQ-019 timeout_cnt  out  8  total RX timeouts, saturating at 255.
REQ-020 busy  out  1  1 in any state except IDLE.

Function
REQ-021 States: IDLE, ISSUE, TX_WAIT, RX_WAIT, EVAL, GAP.
REQ-022 Period timer free-runs while enable=1, wraps at POLL_PERIOD-1 and sets sticky poll_due; cleared to 0 when enable=0.
REQ-023 IDLE->ISSUE when enable=1 and (host_req or poll_due); host_req wins on simultaneous request, poll_due remains pending.
REQ-024 Scheduled command = CMD_INFO (0x00) when dev_present=0, else CMD_POLL (0x01); issuing clears poll_due.
REQ-025 ISSUE lasts one cycle: tx_start=1, tx_byte loaded, host_ack=1 if host command selected; ->TX_WAIT.
REQ-026 TX_WAIT->RX_WAIT on tx_done; no timeout in TX_WAIT.
REQ-027 RX_WAIT counts cycles; rx_done ->EVAL; count reaching RX_TIMEOUT-1 without rx_done -> EVAL as a miss, timeout_cnt+1 saturating.
REQ-028 rx_done or tx_done outside its wait state is ignored.
REQ-029 EVAL success: rx_err=0 and rx_byte_cnt equals expected length (INFO 3, POLL 4, host any >=1).
REQ-030 Success: miss counter cleared, dev_present<=1, poll_stb pulses if command was POLL.
REQ-031 Failure: miss counter+1; reaching MISS_LIMIT sets dev_present<=0 and clears miss counter.
REQ-032 EVAL->GAP; GAP counts GAP_CYCLES then ->IDLE.
REQ-033 enable falling mid-transaction: transaction completes normally, no new issue until enable=1.
REQ-034 Latency IDLE request to tx_start: 2 cycles.

Reset
REQ-035 rst_n=0: state IDLE, all outputs 0, tx_byte 0x00, counters and poll_due 0, dev_present 0.
REQ-036 Reset mid-transaction aborts immediately; first command after reset is CMD_INFO.

Configuration
REQ-037 JOYBUS_HOST_CMD_EN defined: host port arbitrated per REQ-023.
REQ-038 JOYBUS_HOST_CMD_EN undefined: host_req/host_cmd ignored, host_ack tied 0, ports retained.

Structure
REQ-039 Package joybus_pkg holds CMD_INFO, CMD_POLL, INFO_RSP_LEN=3, POLL_RSP_LEN=4, state enum typedef.
REQ-040 Sub-module joybus_poll_timer implements period timer and poll_due.

Verification
REQ-041 Reset, enable=1, POLL_PERIOD=100: tx_byte=0x00 issued; rx_done cnt=3 -> dev_present=1; next issue 0x01.
REQ-042 Present, POLL, rx_done cnt=4 rx_err=0 -> poll_stb one pulse; cnt=2 -> no poll_stb, miss+1.
REQ-043 No rx_done x3, RX_TIMEOUT=50 -> timeout_cnt=3, dev_present=0, next command 0x00.
REQ-044 host_req=1 host_cmd=0xFF with poll_due same cycle -> host 0xFF first with host_ack, then 0x01 after GAP.
REQ-045 rst_n low during RX_WAIT -> busy=0 next cycle; after release first tx_byte=0x00.
REQ-046 Build without JOYBUS_HOST_CMD_EN, host_req=1 -> host_ack never 1, only scheduled commands.
